// File: rtl/mem_ctrl.sv
// mem_ctrl: single-ported DEPTH x DATA_W memory shared by an instruction read
// port and a data read/write port. Fixed priority arbitration (data wins), one
// transaction in flight, WAIT_STATES extra access cycles per transaction.
//
// Optional feature macro: MEM_CTRL_RANGE_ERR_EN
//   defined   -> err pulses with the valid of any access whose address >= DEPTH
//   undefined -> err is tied low (out-of-range accesses are still suppressed)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready; a request is granted in the same cycle it is presented
// WAIT  | transaction latched, counting down extra access cycles
`timescale 1ns/1ps

module mem_ctrl #(
    parameter int                 DATA_W        = 32,
    parameter int                 ADDR_W        = 9,
    parameter int                 DEPTH         = 512,
    parameter int                 WAIT_STATES   = 0,
    parameter logic [DATA_W-1:0]  INIT_DATA_OUT = '0
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;

    // latched transaction; r_port = 1 means data port
    logic                r_port;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_i_gnt;
    logic                w_d_gnt;
    logic                w_gnt;

    // the array access happening at the end of this cycle
    logic                w_acc;
    logic                w_acc_port;
    logic                w_acc_we;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_in_range;
    logic [DATA_W-1:0]   w_rd;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                r_i_valid;
    logic                r_d_valid;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    // FSM next state, grants and access selection; with no wait states the
    // access uses the request inputs directly so it lands on the grant edge
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_i_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        w_acc       = 1'b0;
        w_acc_port  = r_port;
        w_acc_we    = r_we;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        if (!clear) begin
            case (r_state)
                IDLE: begin
                    w_d_gnt = d_req;
                    w_i_gnt = i_req & ~d_req;
                    if (WAIT_STATES == 0) begin
                        w_acc       = d_req | i_req;
                        w_acc_port  = d_req;
                        w_acc_we    = d_req & d_we;
                        w_acc_addr  = d_req ? d_addr : i_addr;
                        w_acc_wdata = d_wdata;
                    end else if (d_req | i_req) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        w_acc       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_gnt      = w_i_gnt | w_d_gnt;
    assign i_gnt      = w_i_gnt;
    assign d_gnt      = w_d_gnt;
    assign w_in_range = (32'(w_acc_addr) < 32'(DEPTH));
    assign w_rd       = w_in_range ? r_mem[w_acc_addr] : '0;

    // state register and wait counter
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // capture the granted transaction for the wait-state path
    always_ff @(posedge clk) begin
        if (clear) begin
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_gnt) begin
            r_port  <= w_d_gnt;
            r_we    <= w_d_gnt & d_we;
            r_addr  <= w_d_gnt ? d_addr : i_addr;
            r_wdata <= d_wdata;
        end
    end

    // storage array; deliberately not touched by clear
    always_ff @(posedge clk) begin
        if (w_acc && w_acc_we && w_in_range) begin
            r_mem[w_acc_addr] <= w_acc_wdata;
        end
    end

    // response pulses and per-port read data
    always_ff @(posedge clk) begin
        if (clear) begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_i_rdata <= INIT_DATA_OUT;
            r_d_rdata <= INIT_DATA_OUT;
        end else begin
            r_i_valid <= w_acc & ~w_acc_port;
            r_d_valid <= w_acc & w_acc_port;
            if (w_acc && !w_acc_we) begin
                if (w_acc_port) begin
                    r_d_rdata <= w_rd;
                end else begin
                    r_i_rdata <= w_rd;
                end
            end
        end
    end

    assign i_valid = r_i_valid;
    assign d_valid = r_d_valid;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

`ifdef MEM_CTRL_RANGE_ERR_EN
    logic r_err;

    // flag out-of-range accesses alongside their valid pulse
    always_ff @(posedge clk) begin
        if (clear) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_acc & ~w_in_range;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
